// File: rtl/signed_pow2_divider_iterative.sv
`default_nettype none
// ============================================================================
// Module   : signed_pow2_divider_iterative
// Purpose  : Multi-cycle signed divide by 2^s. The shift amount s is chosen
//            per transaction. The rounding is either floor (like >>>) or
//            truncate toward zero (like a / 2**s). An inexact flag reports
//            whether any nonzero bit was shifted out. The unit shifts STEP
//            bits per cycle, so STEP trades shifter width against latency.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            in_valid/ready - request handshake
//            in_data        - signed dividend (N bits)
//            in_shift       - shift amount s (SHW bits; s >= N saturates to N)
//            in_mode        - 0 = floor, 1 = truncate toward zero
//            out_valid/ready- result handshake
//            out_data       - signed quotient (N bits)
//            out_inexact    - at least one nonzero bit was discarded
// Revision : 1.0 - initial release
// ============================================================================
module signed_pow2_divider_iterative #(
  parameter int N    = 8,
  parameter int SHW  = 4,
  parameter int STEP = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_data,
  input  logic [SHW-1:0] in_shift,
  input  logic           in_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_inexact
);

  // Wide enough to hold a remaining shift count of N.
  localparam int RW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic            mode_q, mode_d;
  logic            sticky_q, sticky_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic            out_inexact_q, out_inexact_d;

  logic [RW-1:0]   eff_s;
  logic [RW-1:0]   k;
  logic [RW-1:0]   rem_next;
  logic [N-1:0]    shifted;
  logic [N-1:0]    drop_mask;
  logic            dropped_nz;
  logic            sticky_next;
  logic            round_up;

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign out_valid   = (state_q == S_DONE);
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

  // Datapath for one SHIFT cycle.
  always_comb begin
    eff_s       = (32'(in_shift) >= 32'(N)) ? RW'(N) : RW'(in_shift);
    k           = (rem_q < RW'(STEP)) ? rem_q : RW'(STEP);
    shifted     = $signed(data_q) >>> k;
    drop_mask   = ~({N{1'b1}} << k);
    dropped_nz  = |(data_q & drop_mask);
    sticky_next = sticky_q | dropped_nz;
    rem_next    = rem_q - k;
    // An arithmetic shift keeps the sign bit, so data_q[N-1] is still the
    // sign of the original dividend. Truncation differs from floor only for
    // negative dividends with a nonzero remainder.
    round_up    = mode_q & data_q[N-1] & sticky_next;
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    mode_d        = mode_q;
    sticky_d      = sticky_q;
    rem_d         = rem_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          data_d   = in_data;
          mode_d   = in_mode;
          sticky_d = 1'b0;
          rem_d    = eff_s;
          if (eff_s == '0) begin
            out_data_d    = in_data;
            out_inexact_d = 1'b0;
            state_d       = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        data_d   = shifted;
        sticky_d = sticky_next;
        rem_d    = rem_next;
        if (rem_next == '0) begin
          // The floor result is at least -2^(N-1-s), so +1 cannot overflow.
          out_data_d    = shifted + {{(N-1){1'b0}}, round_up};
          out_inexact_d = sticky_next;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      data_q        <= '0;
      mode_q        <= 1'b0;
      sticky_q      <= 1'b0;
      rem_q         <= '0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      mode_q        <= mode_d;
      sticky_q      <= sticky_d;
      rem_q         <= rem_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_pow2_divider_iterative.sv
`default_nettype none
// ============================================================================
// Module   : tb_signed_pow2_divider_iterative
// Purpose  : Self-checking bench for signed_pow2_divider_iterative. Three
//            instances (STEP = 1, 3, 8) each get a driver that pushes
//            expected results into a queue and a monitor that pops and
//            compares on every output transfer.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_signed_pow2_divider_iterative;

  localparam int N   = 8;
  localparam int SHW = 4;
  localparam int NI  = 3;

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 8);
  endfunction

  typedef struct {
    int data;
    int inex;
    int lat;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: quotient from plain integer arithmetic on the dividend.
  function automatic void ref_model(input int a, input int s, input int mode,
                                    output int q, output int inex);
    int e;
    int d;
    e = (s > N) ? N : s;
    d = 1 << e;
    inex = ((a % d) != 0) ? 1 : 0;
    if (mode == 1) q = a / d;
    else           q = a >>> e;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    localparam int ST   = step_of(gi);
    localparam int NOPS = (gi == 0) ? 400 : 300;

    logic           rst_l;
    logic           iv;
    logic           ir;
    logic [N-1:0]   id;
    logic [SHW-1:0] is;
    logic           im;
    logic           ov;
    logic           ordy;
    logic [N-1:0]   od;
    logic           oi;
    logic           rst_smp = 1'b1;
    logic           seen = 1'b0;
    logic [N-1:0]   hold_d;
    logic           hold_i;
    int             bp_mode = 0;
    exp_t           q[$];
    exp_t           e_pop;

    signed_pow2_divider_iterative #(.N(N), .SHW(SHW), .STEP(ST)) u_dut (
      .clk        (clk),
      .rst        (rst_l),
      .in_valid   (iv),
      .in_ready   (ir),
      .in_data    (id),
      .in_shift   (is),
      .in_mode    (im),
      .out_valid  (ov),
      .out_ready  (ordy),
      .out_data   (od),
      .out_inexact(oi)
    );

    always @(posedge clk) rst_smp <= rst_l;

    // Monitor: drives out_ready, checks latency, hold stability and data.
    always @(negedge clk) begin
      if (bp_mode == 0) ordy = ($urandom_range(0, 3) != 0);
      else              ordy = (bp_mode == 2);
      if (rst_smp) begin
        chk("rst_out_valid", int'(ov), 0);
        seen = 1'b0;
      end else if (ov) begin
        if (q.size() == 0) begin
          chk("stale_result", 1, 0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            seen   = 1'b1;
            hold_d = od;
            hold_i = oi;
          end else begin
            chk("hold_data", int'(od), int'(hold_d));
            chk("hold_inexact", int'(oi), int'(hold_i));
          end
          if (ordy) begin
            e_pop = q.pop_front();
            chk("data", int'($signed(od)), e_pop.data);
            chk("inexact", int'(oi), e_pop.inex);
            seen = 1'b0;
          end
        end
      end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int a, input int s, input int mode,
                        input int eq, input int ei);
      int   w;
      int   e;
      exp_t ex;
      iv = 1'b1;
      id = N'(a);
      is = SHW'(s);
      im = mode[0];
      w  = 0;
      while (!ir && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!ir) begin
        chk("accept_timeout", 0, 1);
      end else begin
        e       = (s > N) ? N : s;
        ex.data = eq;
        ex.inex = ei;
        ex.lat  = 1 + (e + ST - 1) / ST;
        ex.acc  = cyc;
        q.push_back(ex);
      end
      @(negedge clk);
      iv = 1'b0;
    endtask

    task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 300) begin
        @(negedge clk);
        w++;
      end
      chk("drain", q.size(), 0);
    endtask

    initial begin
      int w;
      int a;
      int s;
      int m;
      int eq;
      int ei;
      rst_l = 1'b1;
      iv    = 1'b0;
      id    = '0;
      is    = '0;
      im    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", int'(ir), 0);
      chk("reset_out_valid", int'(ov), 0);
      chk("reset_out_data", int'(od), 0);
      chk("reset_inexact", int'(oi), 0);
      rst_l = 1'b0;
      #1 chk("ready_after_reset", int'(ir), 1);
      @(negedge clk);

      // Directed vectors with hand-derived results.
      send(-13, 2, 0, -4, 1);
      send(-13, 2, 1, -3, 1);
      send(100, 3, 1, 12, 1);
      send(-16, 4, 0, -1, 0);
      send(-16, 4, 1, -1, 0);
      send(-128, 0, 0, -128, 0);
      send(-128, 12, 0, -1, 1);
      send(-128, 12, 1, 0, 1);
      send(0, 8, 0, 0, 0);
      send(127, 15, 0, 0, 1);
      drain();

      // Backpressure: hold the result for 5 cycles, poke in_valid meanwhile.
      bp_mode = 1;
      send(-13, 2, 1, -3, 1);
      w = 0;
      while (!ov && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("bp_reach_done", int'(ov), 1);
      repeat (5) begin
        @(negedge clk);
        iv = 1'b1;
        id = 8'h55;
        is = 4'd1;
        #1;
        chk("bp_in_ready", int'(ir), 0);
        chk("bp_out_valid", int'(ov), 1);
      end
      iv = 1'b0;
      bp_mode = 2;
      w = 0;
      while (ov && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("bp_released", int'(ov), 0);
      chk("bp_ready_after", int'(ir), 1);
      bp_mode = 0;
      drain();

      // Reset in the middle of an operation: the result must never appear.
      send(-7, 5, 0, -1, 1);
      q.delete();
      rst_l = 1'b1;
      #1 chk("rst_in_ready", int'(ir), 0);
      @(negedge clk);
      chk("rst_mid_out_valid", int'(ov), 0);
      chk("rst_mid_in_ready", int'(ir), 0);
      rst_l = 1'b0;
      #1 chk("rst_release_ready", int'(ir), 1);
      repeat (12) @(negedge clk);

      // Randomised regression with random gaps on both sides.
      for (int n = 0; n < NOPS; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        a = int'($urandom_range(0, 255)) - 128;
        s = int'($urandom_range(0, 15));
        m = int'($urandom_range(0, 1));
        ref_model(a, s, m, eq, ei);
        send(a, s, m, eq, ei);
      end
      drain();
      done_cnt++;
    end
  end

  initial begin
    while (done_cnt < NI && cyc < 60000) @(negedge clk);
    if (done_cnt < NI) chk("global_timeout", done_cnt, NI);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
